cpu_dispatch: RTL
=================

CPU_DISPATCH -- requirements
Module: cpu_dispatch

Interface
REQ-001 SHALL have parameter N_CORES, default 4: number of bpfcpu cores served (2..8).
REQ-002 SHALL have parameter TAG_WIDTH, default 4: width of the packet tag.
REQ-003 SHALL have parameter PLEN_WIDTH, default 32: width of the packet byte length.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pkt_vld  input  1  upstream packet buffer ready for filtering.
REQ-007 SHALL have port pkt_tag  input  TAG_WIDTH  buffer identifier.
REQ-008 SHALL have port pkt_len  input  PLEN_WIDTH  packet byte length.
REQ-009 SHALL have port pkt_rdy  output  1  dispatcher can take a packet.
REQ-010 SHALL have port core_rdy_for_cpu  output  N_CORES  per-core start offer.
REQ-011 SHALL have port core_byte_len  output  N_CORES*PLEN_WIDTH  per-core latched length, core i at slice i.
REQ-012 SHALL have port core_ack  input  N_CORES  per-core rdy_for_cpu_ack.
REQ-013 SHALL have ports core_acc and core_rej  input  N_CORES each  per-core verdict pulses.
REQ-014 SHALL have ports vrd_vld  output  1; vrd_tag  output  TAG_WIDTH; vrd_acc  output  1 (1=accept, 0=reject); vrd_core  output  3  index of the source core.
REQ-015 SHALL have port vrd_rdy  input  1  downstream takes the verdict.
REQ-016 SHALL have port busy_mask  output  N_CORES  bit i high when core i is not IDLE.
REQ-017 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL keep one FSM per core: IDLE -> OFFER -> RUN -> DONE -> IDLE.
REQ-019 SHALL drive pkt_rdy high iff at least one core is IDLE, derived from registered state only.
REQ-020 SHALL, on pkt_vld && pkt_rdy, select an IDLE core round-robin, searching from (last_grant+1) mod N_CORES. The chosen core SHALL latch pkt_tag and pkt_len and enter OFFER; last_grant SHALL update to that core.
REQ-021 SHALL drive core_rdy_for_cpu[i] high exactly while core i is in OFFER. This gives a 1-cycle latency from packet acceptance to offer.
REQ-022 SHALL move core i from OFFER to RUN on the edge where core_rdy_for_cpu[i] && core_ack[i] is high. If ack is low, the core SHALL stay in OFFER indefinitely.
REQ-023 SHALL move core i from RUN to DONE on the first cycle core_acc[i] or core_rej[i] is high, latching acc = core_acc[i] && !core_rej[i].
REQ-024 SHALL, when core_acc[i] and core_rej[i] are high on the same cycle, record a reject and set err.
REQ-025 SHALL ignore core_acc/core_rej in any state other than RUN and set err.
REQ-026 SHALL hold the vrd_* outputs in a single register stage.
REQ-027 SHALL load the vrd_* register when (!vrd_vld || vrd_rdy) and any core is in DONE. The source core SHALL be picked round-robin from (last_drain+1) mod N_CORES, and that core SHALL return to IDLE on the same edge.
REQ-028 SHALL clear vrd_vld on vrd_vld && vrd_rdy when no core is in DONE.
REQ-029 SHALL keep vrd_* stable while vrd_vld && !vrd_rdy.
REQ-030 SHALL give a latency of 2 cycles from a verdict pulse to vrd_vld when the output register is free.
REQ-031 SHALL not offer a core freed on edge t to a new packet before cycle t+1.
REQ-032 SHALL keep err sticky until reset.
REQ-033 SHALL keep the grant and drain pointers independent.
REQ-034 SHALL hold core_byte_len[i] constant from OFFER through DONE.

Reset
REQ-035 SHALL, while rst is low, force every core to IDLE immediately, regardless of clock.
REQ-036 SHALL, while rst is low, drive vrd_vld, vrd_acc, vrd_tag, vrd_core, core_rdy_for_cpu, busy_mask and err to 0.
REQ-037 SHALL, while rst is low, clear latched tags and lengths to 0 and set last_grant = last_drain = N_CORES-1, so the first grant and first drain start at core 0.
REQ-038 SHALL, on reset asserted mid-operation, discard any in-flight packet and pending verdict.
REQ-039 SHALL report pkt_rdy = 1 on the first clock after rst deasserts.

Verification
REQ-040 SHALL cover: reset, then pkt_vld with tag=3 and len=64, core_ack=4'b1111 -> core_rdy_for_cpu=0001 next cycle, RUN the cycle after; core_acc[0] pulse -> two cycles later vrd_vld=1, vrd_tag=3, vrd_acc=1, vrd_core=0.
REQ-041 SHALL cover: four back-to-back packets with tags 1..4 and no verdicts -> granted to cores 0,1,2,3 in order; pkt_rdy=0 afterward; a fifth packet stalls until a verdict drains.
REQ-042 SHALL cover: cores 1 and 2 pulse rej on the same cycle with vrd_rdy=1 -> verdicts drain core 1 then core 2 on consecutive cycles, both with vrd_acc=0.
REQ-043 SHALL cover: vrd_rdy=0 for 5 cycles with a verdict pending -> vrd_* unchanged throughout; the source core stays non-IDLE until loaded; later verdicts remain in DONE.
REQ-044 SHALL cover: core_acc[2] and core_rej[2] high together while core 2 is in RUN -> vrd_acc=0 and err=1 and stays 1; core_acc[3] while core 3 is IDLE -> ignored, err=1.
REQ-045 SHALL cover: rst pulsed low mid-RUN with vrd_vld=1 -> all outputs 0 asynchronously; after release the next packet goes to core 0.

Source files
------------

// File: rtl/cpu_dispatch.sv
// Round-robin packet dispatcher for N_CORES bpfcpu cores: offer 1 cycle after accept, verdict 2 cycles after the core's pulse.
// pkt_rdy drops when no core is IDLE; vrd_* is held while vrd_rdy is low and finished cores wait in DONE.
module cpu_dispatch #(
  parameter int N_CORES    = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int PLEN_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pkt_vld,
  input  logic [TAG_WIDTH-1:0]          pkt_tag,
  input  logic [PLEN_WIDTH-1:0]         pkt_len,
  output logic                          pkt_rdy,
  output logic [N_CORES-1:0]            core_rdy_for_cpu,
  output logic [N_CORES*PLEN_WIDTH-1:0] core_byte_len,
  input  logic [N_CORES-1:0]            core_ack,
  input  logic [N_CORES-1:0]            core_acc,
  input  logic [N_CORES-1:0]            core_rej,
  output logic                          vrd_vld,
  output logic [TAG_WIDTH-1:0]          vrd_tag,
  output logic                          vrd_acc,
  output logic [2:0]                    vrd_core,
  input  logic                          vrd_rdy,
  output logic [N_CORES-1:0]            busy_mask,
  output logic                          err
);

  localparam int IDXW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state [N_CORES];
  logic [TAG_WIDTH-1:0]  r_tag   [N_CORES];
  logic [PLEN_WIDTH-1:0] r_len   [N_CORES];
  logic [N_CORES-1:0]    r_acc;
  logic [IDXW-1:0]       r_last_grant;
  logic [IDXW-1:0]       r_last_drain;
  logic                  r_vrd_vld;
  logic [TAG_WIDTH-1:0]  r_vrd_tag;
  logic                  r_vrd_acc;
  logic [2:0]            r_vrd_core;
  logic                  r_err;

  logic [N_CORES-1:0] w_idle;
  logic [N_CORES-1:0] w_offer;
  logic [N_CORES-1:0] w_run;
  logic [N_CORES-1:0] w_done;
  logic               w_grant_vld;
  logic [IDXW-1:0]    w_grant_idx;
  logic               w_drain_vld;
  logic [IDXW-1:0]    w_drain_idx;
  logic               w_accept;
  logic               w_out_free;
  logic               w_proto_err;

  function automatic logic [IDXW-1:0] f_wrap(input logic [IDXW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_CORES) s = s - N_CORES;
    return s[IDXW-1:0];
  endfunction

  always_comb begin
    w_idle  = '0;
    w_offer = '0;
    w_run   = '0;
    w_done  = '0;
    for (int i = 0; i < N_CORES; i++) begin
      w_idle[i]  = (r_state[i] == S_IDLE);
      w_offer[i] = (r_state[i] == S_OFFER);
      w_run[i]   = (r_state[i] == S_RUN);
      w_done[i]  = (r_state[i] == S_DONE);
    end
  end

  // Both searches start one past the last winner, so every core gets a turn.
  assign w_out_free = !r_vrd_vld || vrd_rdy;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_drain_vld = 1'b0;
    w_drain_idx = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      if (!w_grant_vld && w_idle[f_wrap(r_last_grant, k)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = f_wrap(r_last_grant, k);
      end
      if (w_out_free && !w_drain_vld && w_done[f_wrap(r_last_drain, k)]) begin
        w_drain_vld = 1'b1;
        w_drain_idx = f_wrap(r_last_drain, k);
      end
    end
  end

  assign w_accept    = pkt_vld && w_grant_vld;
  assign w_proto_err = (|((core_acc | core_rej) & ~w_run)) || (|(core_acc & core_rej & w_run));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CORES; i++) begin
        r_state[i] <= S_IDLE;
        r_tag[i]   <= '0;
        r_len[i]   <= '0;
      end
      r_acc        <= '0;
      r_last_grant <= IDXW'(N_CORES - 1);
      r_last_drain <= IDXW'(N_CORES - 1);
      r_vrd_vld    <= 1'b0;
      r_vrd_tag    <= '0;
      r_vrd_acc    <= 1'b0;
      r_vrd_core   <= '0;
      r_err        <= 1'b0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_accept && (w_grant_idx == IDXW'(i))) begin
              r_state[i] <= S_OFFER;
              r_tag[i]   <= pkt_tag;
              r_len[i]   <= pkt_len;
            end
          end
          S_OFFER: begin
            if (core_ack[i]) r_state[i] <= S_RUN;
          end
          S_RUN: begin
            if (core_acc[i] || core_rej[i]) begin
              r_state[i] <= S_DONE;
              r_acc[i]   <= core_acc[i] && !core_rej[i];
            end
          end
          S_DONE: begin
            if (w_drain_vld && (w_drain_idx == IDXW'(i))) r_state[i] <= S_IDLE;
          end
          default: r_state[i] <= S_IDLE;
        endcase
      end
      if (w_accept) r_last_grant <= w_grant_idx;
      if (w_drain_vld) begin
        r_vrd_vld    <= 1'b1;
        r_vrd_tag    <= r_tag[w_drain_idx];
        r_vrd_acc    <= r_acc[w_drain_idx];
        r_vrd_core   <= 3'(w_drain_idx);
        r_last_drain <= w_drain_idx;
      end else if (r_vrd_vld && vrd_rdy) begin
        r_vrd_vld <= 1'b0;
      end
      if (w_proto_err) r_err <= 1'b1;
    end
  end

  always_comb begin
    core_byte_len = '0;
    for (int i = 0; i < N_CORES; i++) begin
      core_byte_len[i*PLEN_WIDTH +: PLEN_WIDTH] = r_len[i];
    end
  end

  assign pkt_rdy          = |w_idle;
  assign core_rdy_for_cpu = w_offer;
  assign busy_mask        = ~w_idle;
  assign vrd_vld          = r_vrd_vld;
  assign vrd_tag          = r_vrd_tag;
  assign vrd_acc          = r_vrd_acc;
  assign vrd_core         = r_vrd_core;
  assign err              = r_err;

endmodule
